// File: rtl/serial_alu.sv
// Bit-serial ALU: a single 1-bit slice walks the operands LSB to MSB, one bit per clock,
// with the ripple carry held in a register between steps. The MSB step also resolves SLT and overflow.
module serial_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             a_invert,
   input  logic             b_invert,
   input  logic [1:0]       operation,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic               a_inv_q, a_inv_d, b_inv_q, b_inv_d;
   logic [1:0]         op_q, op_d;
   logic               carry_q, carry_d, overflow_q, overflow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic accept_s, msb_s, ai_s, bi_s, sum_s, cout_s, ovf_s, bit_s;

   // start is honoured only outside COMPUTE, so DONE can chain straight into the next operation
   assign accept_s = start && (state_q != S_COMPUTE);
   assign msb_s    = (cnt_q == CNT_W'(WIDTH - 1));

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    state_d = accept_s ? S_COMPUTE : S_IDLE;
         S_COMPUTE: state_d = msb_s ? S_DONE : S_COMPUTE;
         S_DONE:    state_d = accept_s ? S_COMPUTE : S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_COMPUTE: busy = 1'b1;
         S_DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // 1-bit slice for the current bit position
   always_comb begin
      ai_s   = a_q[cnt_q] ^ a_inv_q;
      bi_s   = b_q[cnt_q] ^ b_inv_q;
      sum_s  = ai_s ^ bi_s ^ carry_q;
      cout_s = (ai_s & bi_s) | (ai_s & carry_q) | (bi_s & carry_q);
      ovf_s  = carry_q ^ cout_s;
      case (op_q)
         OP_AND:  bit_s = ai_s & bi_s;
         OP_OR:   bit_s = ai_s | bi_s;
         OP_ADD:  bit_s = sum_s;
         OP_SLT:  bit_s = 1'b0;
         default: bit_s = 1'b0;
      endcase
   end

   // datapath next-state: latch on accept, step one bit per cycle in COMPUTE, hold otherwise
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      a_inv_d    = a_inv_q;
      b_inv_d    = b_inv_q;
      op_d       = op_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      if (accept_s) begin
         a_d        = a;
         b_d        = b;
         a_inv_d    = a_invert;
         b_inv_d    = b_invert;
         op_d       = operation;
         carry_d    = b_invert;
         cnt_d      = '0;
         result_d   = '0;
         overflow_d = 1'b0;
      end else if (state_q == S_COMPUTE) begin
         result_d[cnt_q] = bit_s;
         carry_d         = cout_s;
         if (msb_s) begin
            cnt_d      = '0;
            overflow_d = (op_q == OP_ADD) ? ovf_s : 1'b0;
            // true sign of a+b: the sum MSB corrected by overflow
            if (op_q == OP_SLT) begin
               result_d[0] = sum_s ^ ovf_s;
            end else begin
               result_d[0] = result_q[0];
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         a_inv_q    <= 1'b0;
         b_inv_q    <= 1'b0;
         op_q       <= 2'b00;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         a_inv_q    <= a_inv_d;
         b_inv_q    <= b_inv_d;
         op_q       <= op_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign result   = result_q;
   assign overflow = overflow_q;
   assign zero     = (result_q == '0);

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed cases plus random operations checked
// against a plain-arithmetic reference model.
module tb_serial_alu;

   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst, start, a_invert, b_invert;
   logic [WIDTH-1:0] a, b;
   logic [1:0]       operation;
   logic             busy, done, zero, overflow;
   logic [WIDTH-1:0] result;

   int checks = 0;
   int errors = 0;

   serial_alu #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .a_invert(a_invert), .b_invert(b_invert), .operation(operation),
      .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: signed 33-bit arithmetic on the (optionally inverted) operands
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mai,
                                 input logic mbi, input logic [1:0] mop,
                                 output logic [31:0] r, output logic o);
      logic [31:0]        x, y;
      logic signed [32:0] full;
      x    = mai ? ~ma : ma;
      y    = mbi ? ~mb : mb;
      full = $signed({x[31], x}) + $signed({y[31], y}) + $signed({32'd0, mbi});
      case (mop)
         2'b00:   r = x & y;
         2'b01:   r = x | y;
         2'b10:   r = full[31:0];
         default: r = (full < 0) ? 32'd1 : 32'd0;
      endcase
      o = (mop == 2'b10) ? (full[32] != full[31]) : 1'b0;
   endfunction

   // Called at a negedge; drives start for the next rising edge
   task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic tai,
                        input logic tbi, input logic [1:0] top);
      a = ta; b = tb; a_invert = tai; b_invert = tbi; operation = top; start = 1'b1;
   endtask

   // Counts rising edges (accept edge included) until done is seen; bounded
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) break;
         if (busy === 1'b1) busy_cnt++;
      end
   endtask

   task automatic run_check(input string tag, input int gap, input logic [31:0] ta,
                            input logic [31:0] tb, input logic tai, input logic tbi,
                            input logic [1:0] top);
      int lat, bc;
      logic [31:0] er;
      logic eo;
      repeat (gap) @(negedge clk);
      model(ta, tb, tai, tbi, top, er, eo);
      issue(ta, tb, tai, tbi, top);
      wait_done(lat, bc);
      chk({tag, "_lat"}, 64'(lat), 64'(LAT));
      chk({tag, "_busy"}, 64'(bc), 64'(WIDTH));
      chk({tag, "_res"}, 64'(result), 64'(er));
      chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
      chk({tag, "_zero"}, 64'(zero), 64'(er == 32'd0));
   endtask

   initial begin
      int lat, bc, seen;
      logic [31:0] ra, rb, held;
      logic [1:0]  rop;
      logic        rai, rbi;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; a_invert = 1'b0; b_invert = 1'b0; operation = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      chk("rst_ovf", 64'(overflow), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1. ADD
      run_check("add", 1, 32'd7, 32'd5, 1'b0, 1'b0, 2'b10);
      chk("add_const", 64'(result), 64'd12);
      // 2. SUB and zero
      run_check("sub", 2, 32'd5, 32'd7, 1'b0, 1'b1, 2'b10);
      chk("sub_const", 64'(result), 64'hFFFF_FFFE);
      run_check("sub_eq", 0, 32'h1234, 32'h1234, 1'b0, 1'b1, 2'b10);
      chk("sub_eq_zero", 64'(zero), 64'd1);
      // 3. overflow
      run_check("ovf_add", 1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b10);
      chk("ovf_add_const", 64'({overflow, result}), 64'h1_8000_0000);
      run_check("ovf_sub", 1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 2'b10);
      chk("ovf_sub_const", 64'({overflow, result}), 64'h1_7FFF_FFFF);
      run_check("ovf_and", 1, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 2'b00);
      chk("ovf_and_const", 64'(overflow), 64'd0);
      // 4. SLT
      run_check("slt_a", 1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 2'b11);
      chk("slt_a_const", 64'(result), 64'd1);
      run_check("slt_b", 1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 2'b11);
      chk("slt_b_const", 64'(result), 64'd0);
      run_check("slt_c", 1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 2'b11);
      chk("slt_c_const", 64'(result), 64'd1);
      // 5. logic
      run_check("nor", 1, 32'd0, 32'd0, 1'b1, 1'b1, 2'b00);
      chk("nor_const", 64'(result), 64'hFFFF_FFFF);
      run_check("or", 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0, 2'b01);
      chk("or_const", 64'(result), 64'hFFFF_FFFF);
      run_check("and", 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0, 2'b00);
      chk("and_zero", 64'(zero), 64'd1);
      run_check("nand", 1, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 1'b1, 2'b01);

      // result holds through IDLE
      held = result;
      repeat (5) @(negedge clk);
      chk("hold_result", 64'(result), 64'(held));
      chk("hold_done", 64'(done), 64'd0);

      // 6a. start during COMPUTE is ignored
      issue(32'd100, 32'd23, 1'b0, 1'b0, 2'b10);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      issue(32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, 2'b01);
      wait_done(lat, bc);
      chk("ign_done", 64'(done), 64'd1);
      chk("ign_res", 64'(result), 64'd123);
      // 6b. start in the DONE cycle is accepted back-to-back
      run_check("b2b", 0, 32'd40, 32'd2, 1'b0, 1'b1, 2'b10);
      chk("b2b_const", 64'(result), 64'd38);

      // random operations checked against the model
      for (int i = 0; i < 12; i++) begin
         ra  = $urandom;
         rb  = (i % 4 == 3) ? ra : $urandom;
         rai = 1'($urandom_range(1, 0));
         rbi = 1'($urandom_range(1, 0));
         rop = 2'($urandom_range(3, 0));
         run_check($sformatf("rnd%0d", i), $urandom_range(1, 0), ra, rb, rai, rbi, rop);
      end

      // 6c. reset mid-COMPUTE aborts with no done
      @(negedge clk);
      issue(32'd9, 32'd9, 1'b0, 1'b0, 2'b10);
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_zero", 64'(zero), 64'd1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) seen++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(seen), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial 32-bit ALU sequencer.
- Uses one 1-bit ALU slice and processes one bit per clock, LSB to MSB.
- Latches operands and control on a start pulse and carries the ripple carry in a register between cycles.
- Serves as the low-area alternative to the 32-slice ripple ALU, with the same control encoding.
- Handles the MSB step internally (set, overflow) and returns a packed result with a done pulse.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, latched on an accepted start.
- b  input  WIDTH  operand B, latched on an accepted start.
- a_invert  input  1  Ainvert, latched on an accepted start.
- b_invert  input  1  Binvert, latched on an accepted start; also the initial carry-in.
- operation  input  2  00 AND, 01 OR, 10 ADD, 11 SLT; latched on an accepted start.
- busy  output  1  high while in COMPUTE.
- done  output  1  one-cycle pulse; result, zero and overflow are valid from this cycle on.
- result  output  WIDTH  registered result; held until the next accepted start.
- zero  output  1  high when result == 0; combinational from the result register.
- overflow  output  1  registered signed overflow; ADD-class operations only.

Behaviour:
- Clock and reset:
  - One clock domain (clk); rst is synchronous and active-high.
  - On rst: state = IDLE, busy = 0, done = 0, result = 0, overflow = 0, carry = 0, counter = 0. zero therefore reads 1.
  - rst takes priority over everything. Asserting it mid-COMPUTE aborts the operation, no done is produced, and the partial result is discarded (result = 0).
- States:
  - IDLE: start = 1 latches a, b, a_invert, b_invert and operation; sets carry = b_invert, counter = 0, result = 0; goes to COMPUTE. start = 0 stays in IDLE.
  - COMPUTE: each edge processes bit i = counter.
    - ai = a[i] ^ a_invert; bi = b[i] ^ b_invert.
    - sum = ai ^ bi ^ carry.
    - cout = ai&bi | ai&carry | bi&carry.
    - result[i] = ai&bi for 00, ai|bi for 01, sum for 10, 0 for 11.
    - carry <= cout; counter <= counter + 1.
  - COMPUTE, on the edge where i = WIDTH-1 (MSB step):
    - ovf = carry ^ cout.
    - overflow <= ovf if operation == 10, else 0.
    - If operation == 11: result[0] <= sum ^ ovf (correct signed less-than, including the overflow case); all other bits stay 0.
    - Go to DONE.
  - DONE: done = 1 for exactly this cycle.
    - start = 1 is accepted here, exactly as in IDLE (back-to-back operation, no idle gap).
    - Otherwise go to IDLE.
- Handshake:
  - start is ignored while busy = 1; the latched operands are unaffected.
- Latency:
  - Start accepted at edge 0 → bits processed at edges 1..WIDTH → done high in the cycle after edge WIDTH.
  - That is WIDTH+1 cycles from accept to done (33 for WIDTH = 32).
- Encodings:
  - SUB = {a_inv 0, b_inv 1, op 10}. NOR = {1, 1, 00}. NAND = {1, 1, 01}.
  - SLT with b_invert = 0 is not an error: the block computes SLT from a + b, as the hardware defines.
- Stability:
  - result, zero and overflow hold their values through IDLE until the next accepted start.
  - On that start, result clears to 0 and overflow clears to 0.
- Counter:
  - Never wraps within an operation.
  - Reset to 0 on every accepted start.

Test Plan:
1. ADD: a = 7, b = 5, op = 10, inv = 00 → done exactly 33 cycles after the start edge; result = 12, zero = 0, overflow = 0; busy high for 32 cycles.
2. SUB and zero: a = 5, b = 7, {0,1,10} → result = 0xFFFFFFFE, overflow = 0. Then a = b = 0x1234 → result = 0, zero = 1.
3. Overflow: ADD 0x7FFFFFFF + 1 → result = 0x80000000, overflow = 1. SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow = 1. AND of the same operands → overflow = 0.
4. SLT: a = 0xFFFFFFFF (−1), b = 1 → result = 1. a = 0x7FFFFFFF, b = 0x80000000 → result = 0 (overflow case). a = 0x80000000, b = 0x7FFFFFFF → result = 1.
5. Logic: NOR a = b = 0 → 0xFFFFFFFF. OR 0xF0F0F0F0 | 0x0F0F0F0F → 0xFFFFFFFF. AND of the same → 0, zero = 1.
6. Control: start pulsed with new operands at cycle 10 of COMPUTE → ignored, original result returned. start in the DONE cycle → next op accepted, done again 33 cycles later. rst at cycle 20 of COMPUTE → no done, result = 0, zero = 1, busy = 0 next cycle.
